// File: rtl/uart_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader_if
// Purpose  : Bundles the loader's serial input, load request, RAM write port
//            and processor-control status lines.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx;
  logic              load_req;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  // Loader side: consumes the serial line and request, drives RAM and status.
  modport master (
    input  rx, load_req,
    output mem_write, mem_addr, mem_data, cpu_hold, busy, done, error
  );

  // System side: drives the serial line and request, observes the loader.
  modport slave (
    output rx, load_req,
    input  mem_write, mem_addr, mem_data, cpu_hold, busy, done, error
  );
endinterface
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Purpose  : Receives a length-prefixed program image over an 8N1 UART line,
//            writes it into processor RAM, verifies an 8-bit additive
//            checksum and then releases the processor or flags an error.
//            Image format: count byte (0 = 256), data bytes, checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_prog_loader_if.master bus
);

  localparam int c_CLK_W = $clog2(CLKS_PER_BIT);
  localparam int c_CNT_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam logic [c_CLK_W-1:0] c_HALF_M1 = c_CLK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CLK_W-1:0] c_BIT_M1  = c_CLK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Serial input synchroniser and edge history
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;

  // Receiver
  rx_state_t          r_rx_state;
  logic [c_CLK_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_byte;
  logic               r_byte_valid;
  logic               r_frame_err;

  // Loader
  state_t             r_state;
  logic [7:0]         r_sum;
  logic [c_CNT_W-1:0] r_count;
  logic [ADDR_W-1:0]  r_index;
  logic               r_mem_write;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [7:0]         r_mem_data;
  logic               r_cpu_hold;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic [c_CNT_W-1:0] w_byte_count;
  logic [c_CNT_W-1:0] w_index_next;

  // A count byte of zero stands for a full 256-byte image.
  assign w_byte_count = (r_byte == 8'd0) ? c_CNT_W'(256) : c_CNT_W'(r_byte);
  assign w_index_next = c_CNT_W'(r_index) + c_CNT_W'(1);

  // Two-flop synchroniser; idle-high reset so no false edge comes out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // 8N1 receiver: start-bit qualify at mid-bit, then one sample per bit time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          // Edge (not level) detect so a stuck-low line after a bad stop
          // bit does not retrigger a frame.
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_clk_cnt == c_HALF_M1) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == c_BIT_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == c_BIT_M1) begin
            r_clk_cnt  <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader sequencing, RAM write strobe and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sum       <= '0;
      r_count     <= '0;
      r_index     <= '0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_cpu_hold  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          // Bytes arriving here are ignored; only a request starts a load.
          if (bus.load_req) begin
            r_state    <= S_COUNT;
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_sum      <= '0;
            r_index    <= '0;
          end
        end
        S_COUNT: begin
          if (r_frame_err) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (r_byte_valid) begin
            r_count <= w_byte_count;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_frame_err) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (r_byte_valid) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= r_index;
            r_mem_data  <= r_byte;
            r_sum       <= r_sum + r_byte;
            r_index     <= r_index + 1'b1;
            if (w_index_next == r_count) begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (r_frame_err) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (r_byte_valid) begin
            r_busy <= 1'b0;
            if (r_byte == r_sum) begin
              r_state    <= S_DONE;
              r_cpu_hold <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_prog_loader
// Purpose  : Self-checking bench for uart_prog_loader: table of image loads
//            plus hand-written false-start, re-request and reset sequences.
//            RAM writes are checked against a queue of expected writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

  localparam int CPB = 4;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   write_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_W(AW)) bus ();

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] base;
    logic [7:0] step;
    logic       bad_sum;
    int         ferr_at;
    logic       exp_done;
    logic       exp_error;
    logic       exp_hold;
    int         exp_writes;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CPB);
    end
    bus.rx = stop_val;
    tick(CPB);
    bus.rx = 1'b1;
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    tick(1);
    bus.load_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick(3);
    while (bus.busy === 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_data"},  32'(bus.mem_data),  32'd0);
    check({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_error"},     32'(bus.error),     32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int id);
    int         n;
    logic [7:0] sum;
    logic [7:0] b;
    logic       stopped;
    n = (v.cnt == 8'd0) ? 256 : int'(v.cnt);
    sum = 8'd0;
    stopped = 1'b0;
    write_cnt = 0;
    pulse_load();
    tick(1);
    check($sformatf("v%0d_busy_start", id), 32'(bus.busy), 32'd1);
    check($sformatf("v%0d_hold_start", id), 32'(bus.cpu_hold), 32'd1);
    send_byte(v.cnt, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (!stopped) begin
        b = v.base + v.step * 8'(i);
        if (i == v.ferr_at) begin
          send_byte(b, 1'b0);
          stopped = 1'b1;
        end else begin
          exp_q.push_back({8'(i), b});
          sum = sum + b;
          send_byte(b, 1'b1);
        end
      end
    end
    if (!stopped) send_byte(v.bad_sum ? sum - 8'd1 : sum, 1'b1);
    wait_idle($sformatf("v%0d", id));
    check($sformatf("v%0d_done", id),   32'(bus.done),     32'(v.exp_done));
    check($sformatf("v%0d_error", id),  32'(bus.error),    32'(v.exp_error));
    check($sformatf("v%0d_hold", id),   32'(bus.cpu_hold), 32'(v.exp_hold));
    check($sformatf("v%0d_busy", id),   32'(bus.busy),     32'd0);
    check($sformatf("v%0d_writes", id), 32'(write_cnt),    32'(v.exp_writes));
    check($sformatf("v%0d_q_empty", id), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard: every RAM write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.mem_write === 1'b1) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", bus.mem_addr, bus.mem_data);
      end else begin
        check("mem_write_addr_data", 32'({bus.mem_addr, bus.mem_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //         cnt    base   step   bad   ferr done err  hold writes
    vecs[0] = '{8'h03, 8'h11, 8'h11, 1'b0, -1, 1'b1, 1'b0, 1'b0, 3};
    vecs[1] = '{8'h03, 8'h11, 8'h11, 1'b1, -1, 1'b0, 1'b1, 1'b1, 3};
    vecs[2] = '{8'h03, 8'h11, 8'h11, 1'b0,  1, 1'b0, 1'b1, 1'b1, 1};
    vecs[3] = '{8'h00, 8'h00, 8'h01, 1'b0, -1, 1'b1, 1'b0, 1'b0, 256};
    vecs[4] = '{8'h01, 8'hA5, 8'h00, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{8'h05, 8'hF0, 8'h37, 1'b0, -1, 1'b1, 1'b0, 1'b0, 5};

    bus.rx = 1'b1;
    bus.load_req = 1'b0;
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    for (int k = 0; k < 6; k++) apply_vec(vecs[k], k);

    // False start: a one-cycle glitch must not be taken as a byte.
    write_cnt = 0;
    pulse_load();
    tick(2);
    bus.rx = 1'b0;
    tick(1);
    bus.rx = 1'b1;
    tick(20);
    check("fs_busy", 32'(bus.busy), 32'd1);
    check("fs_done", 32'(bus.done), 32'd0);
    send_byte(8'h02, 1'b1);
    exp_q.push_back({8'h00, 8'h12});
    send_byte(8'h12, 1'b1);
    exp_q.push_back({8'h01, 8'h34});
    send_byte(8'h34, 1'b1);
    send_byte(8'h46, 1'b1);
    wait_idle("fs");
    check("fs_done_end", 32'(bus.done), 32'd1);
    check("fs_writes", 32'(write_cnt), 32'd2);

    // Re-request mid-load must not clear the write index.
    write_cnt = 0;
    pulse_load();
    send_byte(8'h03, 1'b1);
    exp_q.push_back({8'h00, 8'h01});
    send_byte(8'h01, 1'b1);
    pulse_load();
    exp_q.push_back({8'h01, 8'h02});
    send_byte(8'h02, 1'b1);
    exp_q.push_back({8'h02, 8'h03});
    send_byte(8'h03, 1'b1);
    send_byte(8'h06, 1'b1);
    wait_idle("rr");
    check("rr_done", 32'(bus.done), 32'd1);
    check("rr_writes", 32'(write_cnt), 32'd3);

    // Reset in the middle of the third data frame.
    write_cnt = 0;
    pulse_load();
    send_byte(8'h03, 1'b1);
    exp_q.push_back({8'h00, 8'hAA});
    send_byte(8'hAA, 1'b1);
    exp_q.push_back({8'h01, 8'hBB});
    send_byte(8'hBB, 1'b1);
    begin
      int n;
      n = 0;
      while (write_cnt < 2 && n < 100) begin
        tick(1);
        n++;
      end
      check("rm_writes_before", 32'(write_cnt), 32'd2);
    end
    bus.rx = 1'b0;
    tick(CPB);
    bus.rx = 1'b1;
    tick(CPB);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("rm");
    tick(CPB * 12);
    rst = 1'b0;
    tick(2);
    check("rm_q_empty", 32'(exp_q.size()), 32'd0);
    apply_vec(vecs[0], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
